// File: rtl/bandit_game_ctrl_pkg.sv
// Shared definitions for the one-arm bandit: screen/state codes, timing
// defaults and credit width. Message generators import this as well.
package bandit_pkg;

    typedef enum logic [3:0] {
        ST_WELCOME = 4'd0,
        ST_GAME    = 4'd1,
        ST_SCORE   = 4'd2,
        ST_ERROR   = 4'd3,
        ST_COIN    = 4'd4
    } state_e;

    localparam int unsigned REF_DIV_DEF    = 50000;
    localparam int unsigned COIN_HOLD_DEF  = 100000000;
    localparam int unsigned SCORE_HOLD_DEF = 150000000;
    localparam int unsigned ERR_HOLD_DEF   = 100000000;
    localparam int unsigned GAME_MAX_DEF   = 500000000;
    localparam int unsigned CRED_W_DEF     = 4;

    // Largest of four hold lengths; sizes the shared hold timer.
    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/bandit_game_ctrl_if.sv
// Button/coin/scorer inputs and state/display outputs of the game sequencer.
// The controller is the slave; whoever drives the buttons is the master.
interface bandit_game_ctrl_if
    import bandit_pkg::*;
#(
    parameter int CRED_W = CRED_W_DEF
);
    logic              coin_in;
    logic              start_btn;
    logic              stop_btn;
    logic              win;
    logic [CRED_W-1:0] payout;
    logic [3:0]        cur_state;
    logic              state_new;
    logic              ref_sign;
    logic [1:0]        refresh;
    logic [CRED_W-1:0] credits;

    modport master (
        output coin_in, start_btn, stop_btn, win, payout,
        input  cur_state, state_new, ref_sign, refresh, credits
    );

    modport slave (
        input  coin_in, start_btn, stop_btn, win, payout,
        output cur_state, state_new, ref_sign, refresh, credits
    );
endinterface

// File: rtl/bandit_game_ctrl_scan_tick_gen.sv
// Display scan schedule: a prescaler producing a one-cycle ref_sign strobe
// every REF_DIV cycles and a 2-bit digit index advancing on each strobe.
// A restart realigns the schedule and strobes immediately with digit 0.
module scan_tick_gen #(
    parameter int unsigned REF_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    output logic       ref_sign,
    output logic [1:0] refresh
);
    localparam int unsigned DIV_W = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;

    logic [DIV_W-1:0] presc_q;
    logic [1:0]       refresh_q;
    logic             ref_sign_q;

    // Prescaler, digit index and strobe; restart forces an immediate digit-0 strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q    <= '0;
            refresh_q  <= 2'd0;
            ref_sign_q <= 1'b0;
        end else if (restart) begin
            presc_q    <= '0;
            refresh_q  <= 2'd0;
            ref_sign_q <= 1'b1;
        end else if (presc_q == DIV_W'(REF_DIV - 1)) begin
            presc_q    <= '0;
            refresh_q  <= refresh_q + 2'd1;
            ref_sign_q <= 1'b1;
        end else begin
            presc_q    <= presc_q + 1'b1;
            ref_sign_q <= 1'b0;
        end
    end

    assign ref_sign = ref_sign_q;
    assign refresh  = refresh_q;
endmodule

// File: rtl/bandit_game_ctrl.sv
// Master sequencer of the one-arm bandit: game FSM, hold timer, credit
// counter and the display scan schedule feeding the message generators.
module bandit_game_ctrl
    import bandit_pkg::*;
#(
    parameter int unsigned REF_DIV    = REF_DIV_DEF,
    parameter int unsigned COIN_HOLD  = COIN_HOLD_DEF,
    parameter int unsigned SCORE_HOLD = SCORE_HOLD_DEF,
    parameter int unsigned ERR_HOLD   = ERR_HOLD_DEF,
    parameter int unsigned GAME_MAX   = GAME_MAX_DEF,
    parameter int unsigned CRED_W     = CRED_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    bandit_game_ctrl_if.slave  bus
);
    localparam int unsigned HOLD_MAX = max4(COIN_HOLD, SCORE_HOLD, ERR_HOLD, GAME_MAX);
    localparam int unsigned TMR_W    = $clog2(HOLD_MAX) + 1;

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [CRED_W-1:0] credits_q, credits_d;
    logic              win_used_q, win_used_d;
    logic              state_new_q;
    logic              state_change;
    logic              timer_restart;
    logic              credit_dec;
    logic [CRED_W:0]   credit_add;
    logic [CRED_W:0]   credit_sum;

    // State, timer, credits and win-once flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_WELCOME;
            timer_q     <= '0;
            credits_q   <= '0;
            win_used_q  <= 1'b0;
            state_new_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            credits_q   <= credits_d;
            win_used_q  <= win_used_d;
            state_new_q <= state_change;
        end
    end

    // Next-state, credit delta and timer control for the current screen.
    always_comb begin
        state_d       = state_q;
        win_used_d    = win_used_q;
        timer_restart = 1'b0;
        credit_dec    = 1'b0;
        credit_add    = '0;
        timer_d       = timer_q;
        credits_d     = credits_q;
        credit_sum    = '0;

        case (state_q)
            ST_WELCOME: begin
                // Coin takes precedence over a simultaneous start.
                if (bus.coin_in) begin
                    state_d    = ST_COIN;
                    credit_add = (CRED_W+1)'(1);
                end else if (bus.start_btn) begin
                    if (credits_q != '0) begin
                        state_d    = ST_GAME;
                        credit_dec = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_COIN: begin
                if (bus.coin_in) begin
                    credit_add    = (CRED_W+1)'(1);
                    timer_restart = 1'b1;
                end else if (timer_q == TMR_W'(COIN_HOLD - 1)) begin
                    state_d = ST_WELCOME;
                end
            end
            ST_GAME: begin
                if (bus.coin_in) credit_add = (CRED_W+1)'(1);
                if (bus.stop_btn || (timer_q == TMR_W'(GAME_MAX - 1))) state_d = ST_SCORE;
            end
            ST_SCORE: begin
                // Coin and the first win of this visit are folded into one saturating add.
                if (bus.coin_in) credit_add = (CRED_W+1)'(1);
                if (bus.win && !win_used_q) begin
                    credit_add = credit_add + {1'b0, bus.payout};
                    win_used_d = 1'b1;
                end
                if (timer_q == TMR_W'(SCORE_HOLD - 1)) state_d = ST_WELCOME;
            end
            ST_ERROR: begin
                if (bus.coin_in) begin
                    state_d    = ST_COIN;
                    credit_add = (CRED_W+1)'(1);
                end else if (timer_q == TMR_W'(ERR_HOLD - 1)) begin
                    state_d = ST_WELCOME;
                end
            end
            default: state_d = ST_WELCOME;
        endcase

        state_change = (state_d != state_q);

        // Timer restarts on every entry; it saturates so an idle WELCOME cannot wrap it.
        if (state_change) begin
            timer_d    = '0;
            win_used_d = 1'b0;
        end else if (timer_restart) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end

        credit_sum = {1'b0, credits_q} + credit_add;
        if (credit_dec) begin
            credits_d = credits_q - 1'b1;
        end else if (credit_sum[CRED_W]) begin
            credits_d = '1;
        end else begin
            credits_d = credit_sum[CRED_W-1:0];
        end
    end

    scan_tick_gen #(
        .REF_DIV (REF_DIV)
    ) u_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (state_change),
        .ref_sign (bus.ref_sign),
        .refresh  (bus.refresh)
    );

    assign bus.cur_state = state_q;
    assign bus.state_new = state_new_q;
    assign bus.credits   = credits_q;
endmodule
